// File: rtl/seq_divider.sv
// Signed 8-bit restoring divider: 10-edge latency from the Start sampling edge, held result.
// Optional divide-by-zero detection is built when DIVZERO_DETECT_EN is defined.
module seq_divider (
  input  logic       clk,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
`ifdef DIVZERO_DETECT_EN
  output logic       DivZero,
`endif
  output logic       Done
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    dvd_q, dvd_d, dvs_q, dvs_d;
  logic            sn_q, sn_d, sd_q, sd_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    acc_q, acc_d, mag_q, mag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    quo_q, quo_d, rmd_q, rmd_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic [W:0]      sh;

  // State register
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_ITER;
`ifdef DIVZERO_DETECT_EN
        if (dvs_q == '0) state_d = S_DONE;
`endif
      end
      S_ITER: if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (!Start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    sn_d   = sn_q;
    sd_d   = sd_q;
    rem_d  = rem_q;
    acc_d  = acc_q;
    mag_d  = mag_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    dz_d   = dz_q;
    sh     = (W+1)'({rem_q, acc_q[W-1]});
    case (state_q)
      S_IDLE: if (Start) begin
        dvd_d = Dividend;
        dvs_d = Divisor;
        sn_d  = Dividend[W-1];
        sd_d  = Divisor[W-1];
        dz_d  = 1'b0;
      end
      S_LOAD: begin
        // Negating -128 in W bits yields 8'h80, which is the correct unsigned magnitude.
        rem_d = '0;
        acc_d = sn_q ? W'(-dvd_q) : dvd_q;
        mag_d = sd_q ? W'(-dvs_q) : dvs_q;
        cnt_d = '0;
`ifdef DIVZERO_DETECT_EN
        if (dvs_q == '0) begin
          quo_d = '1;
          rmd_d = dvd_q;
          dz_d  = 1'b1;
        end
`endif
      end
      S_ITER: begin
        if (sh >= {1'b0, mag_q}) begin
          rem_d = sh - {1'b0, mag_q};
          acc_d = {acc_q[W-2:0], 1'b1};
        end else begin
          rem_d = sh;
          acc_d = {acc_q[W-2:0], 1'b0};
        end
        cnt_d = CW'(cnt_q + 1'b1);
      end
      S_FIX: begin
        quo_d = (sn_q ^ sd_q) ? W'(-acc_q) : acc_q;
        rmd_d = sn_q ? W'(-rem_q[W-1:0]) : rem_q[W-1:0];
      end
      default: ;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      sn_q   <= 1'b0;
      sd_q   <= 1'b0;
      rem_q  <= '0;
      acc_q  <= '0;
      mag_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rmd_q  <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      sn_q   <= sn_d;
      sd_q   <= sd_d;
      rem_q  <= rem_d;
      acc_q  <= acc_d;
      mag_q  <= mag_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign Done      = done_q;
`ifdef DIVZERO_DETECT_EN
  assign DivZero   = dz_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, randomized operands against an
// arithmetic reference, and multi-cycle sequences for held Start, reset abort and divide-by-zero.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [7:0] Dividend, Divisor, Quotient, Remainder;
  logic       Done;
`ifdef DIVZERO_DETECT_EN
  logic       DivZero;
`endif

  int total = 0;
  int bad   = 0;

  seq_divider dut (
    .clk(clk), .Resetn(Resetn), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder),
`ifdef DIVZERO_DETECT_EN
    .DivZero(DivZero),
`endif
    .Done(Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero, % takes the dividend's sign
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    q  = 8'(ia / ib);
    r  = 8'(ia % ib);
  endtask

  // One division; exp_lat counts edges after the sampling edge until Done
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                         input bit chk_data, input logic [7:0] eq, input logic [7:0] er,
                         input string name);
    int lat;
    @(negedge clk);
    Start = 1'b1; Dividend = a; Divisor = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; Dividend = 8'($urandom); Divisor = 8'($urandom);
    lat = 0;
    while (!Done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
    if (chk_data) begin
      chk({name, ".quotient"}, 32'(Quotient), 32'(eq));
      chk({name, ".remainder"}, 32'(Remainder), 32'(er));
    end
`ifdef DIVZERO_DETECT_EN
    chk({name, ".divzero"}, 32'(DivZero), 32'(exp_lat == 1));
`endif
    @(posedge clk); #1;
    chk({name, ".done_fall"}, 32'(Done), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    logic [7:0] a, b, eq, er;
    int rises, highs;
    logic prev;

    tbl[0] = '{8'd100,  8'd7,    8'd14,  8'd2};
    tbl[1] = '{8'h9C,   8'd7,    8'hF2,  8'hFE};
    tbl[2] = '{8'd100,  8'hF9,   8'hF2,  8'd2};
    tbl[3] = '{8'h80,   8'hFF,   8'h80,  8'd0};
    tbl[4] = '{8'h80,   8'd1,    8'h80,  8'd0};
    tbl[5] = '{8'd127,  8'd1,    8'd127, 8'd0};
    tbl[6] = '{8'hFF,   8'd127,  8'd0,   8'hFF};
    tbl[7] = '{8'h80,   8'd7,    8'hEE,  8'hFE};
    tbl[8] = '{8'd127,  8'h80,   8'd0,   8'd127};
    tbl[9] = '{8'h80,   8'h80,   8'd1,   8'd0};

    Resetn = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
    #12;
    chk("reset.done", 32'(Done), 32'(0));
    chk("reset.quotient", 32'(Quotient), 32'(0));
    chk("reset.remainder", 32'(Remainder), 32'(0));
`ifdef DIVZERO_DETECT_EN
    chk("reset.divzero", 32'(DivZero), 32'(0));
`endif
    @(negedge clk);
    Resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      run_div(tbl[i].a, tbl[i].b, 10, 1'b1, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (b == 8'd0) b = 8'd3;
      model(a, b, eq, er);
      run_div(a, b, 10, 1'b1, eq, er, $sformatf("rnd%0d", i));
    end

`ifdef DIVZERO_DETECT_EN
    run_div(8'd5, 8'd0, 1, 1'b1, 8'hFF, 8'd5, "divzero");
`else
    run_div(8'd5, 8'd0, 10, 1'b0, 8'd0, 8'd0, "divzero");
`endif
    run_div(8'd20, 8'd6, 10, 1'b1, 8'd3, 8'd2, "after_dz");

    // Start held for 30 cycles: exactly one division
    @(negedge clk);
    Start = 1'b1; Dividend = 8'd50; Divisor = 8'd5;
    rises = 0; prev = Done;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (Done && !prev) rises++;
      prev = Done;
    end
    chk("hold.rises", 32'(rises), 32'(1));
    chk("hold.done_high", 32'(Done), 32'(1));
    chk("hold.quotient", 32'(Quotient), 32'(10));
    chk("hold.remainder", 32'(Remainder), 32'(0));
    @(negedge clk);
    Start = 1'b0;
    @(posedge clk); #1;
    chk("hold.done_fall", 32'(Done), 32'(0));
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (Done) highs++;
    end
    chk("hold.no_rerun", 32'(highs), 32'(0));

    // Reset mid-iteration abandons the division and clears outputs at once
    @(negedge clk);
    Start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #2 Resetn = 1'b0;
    #1;
    chk("rst.done", 32'(Done), 32'(0));
    chk("rst.quotient", 32'(Quotient), 32'(0));
    chk("rst.remainder", 32'(Remainder), 32'(0));
    @(negedge clk);
    Resetn = 1'b1;
    run_div(8'd9, 8'd2, 10, 1'b1, 8'd4, 8'd1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
